// File: rtl/cc_pkt_arbiter.sv
// Packet-level round-robin arbiter merging two CC AXIS sources into one
// registered CC stream toward the PCIe hard IP (pcie_clk domain).
module cc_pkt_arbiter #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              pcie_clk,
    input  logic              pcie_rst_n,
    input  logic              s0_axis_cc_tvalid,
    input  logic              s0_axis_cc_tlast,
    input  logic [DATA_W-1:0] s0_axis_cc_tdata,
    input  logic [KEEP_W-1:0] s0_axis_cc_tkeep,
    output logic              s0_axis_cc_tready,
    input  logic              s1_axis_cc_tvalid,
    input  logic              s1_axis_cc_tlast,
    input  logic [DATA_W-1:0] s1_axis_cc_tdata,
    input  logic [KEEP_W-1:0] s1_axis_cc_tkeep,
    output logic              s1_axis_cc_tready,
    output logic              m_axis_cc_tvalid,
    output logic              m_axis_cc_tlast,
    output logic [DATA_W-1:0] m_axis_cc_tdata,
    output logic [KEEP_W-1:0] m_axis_cc_tkeep,
    output logic [32:0]       m_axis_cc_tuser,
    input  logic              m_axis_cc_tready,
    output logic [1:0]        grant_state,
    output logic [CNT_W-1:0]  s0_pkt_cnt,
    output logic [CNT_W-1:0]  s1_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   rr_last_q;
    logic   pick0, pick1;
    logic   s0_rdy, s1_rdy;

    logic              in_acc, in_last;
    logic [DATA_W-1:0] in_data;
    logic [KEEP_W-1:0] in_keep;

    logic              main_vld_q, main_last_q;
    logic [DATA_W-1:0] main_data_q;
    logic [KEEP_W-1:0] main_keep_q;
    logic              skid_vld_q, skid_last_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [KEEP_W-1:0] skid_keep_q;
    logic              main_open;

    logic [CNT_W-1:0]  s0_cnt_q, s1_cnt_q;

    // On contention the source that did not send the previous packet wins.
    assign pick0 = s0_axis_cc_tvalid & (!s1_axis_cc_tvalid | rr_last_q);
    assign pick1 = s1_axis_cc_tvalid & (!s0_axis_cc_tvalid | !rr_last_q);

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s0_rdy  = 1'b0;
        s1_rdy  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!skid_vld_q) begin
                    unique case (1'b1)
                        pick0:   state_d = GNT0;
                        pick1:   state_d = GNT1;
                        default: state_d = IDLE;
                    endcase
                end
            end
            GNT0: begin
                s0_rdy = !skid_vld_q;
                if (s0_rdy && s0_axis_cc_tvalid && s0_axis_cc_tlast) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                s1_rdy = !skid_vld_q;
                if (s1_rdy && s1_axis_cc_tvalid && s1_axis_cc_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_acc  = (s0_rdy & s0_axis_cc_tvalid) | (s1_rdy & s1_axis_cc_tvalid);
    assign in_last = (state_q == GNT1) ? s1_axis_cc_tlast : s0_axis_cc_tlast;
    assign in_data = (state_q == GNT1) ? s1_axis_cc_tdata : s0_axis_cc_tdata;
    assign in_keep = (state_q == GNT1) ? s1_axis_cc_tkeep : s0_axis_cc_tkeep;

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            rr_last_q <= 1'b1;
            s0_cnt_q  <= '0;
            s1_cnt_q  <= '0;
        end else if (in_acc && in_last) begin
            if (state_q == GNT1) begin
                rr_last_q <= 1'b1;
                s1_cnt_q  <= s1_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                rr_last_q <= 1'b0;
                s0_cnt_q  <= s0_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Main register feeds m_*; skid catches the one beat that can arrive
    // after m_tready drops, since upstream ready is skid-empty.
    assign main_open = !main_vld_q || m_axis_cc_tready;

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            main_vld_q  <= 1'b0;
            main_last_q <= 1'b0;
            main_data_q <= '0;
            main_keep_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_keep_q <= '0;
        end else if (main_open) begin
            if (skid_vld_q) begin
                main_vld_q  <= 1'b1;
                main_last_q <= skid_last_q;
                main_data_q <= skid_data_q;
                main_keep_q <= skid_keep_q;
                skid_vld_q  <= 1'b0;
            end else begin
                main_vld_q  <= in_acc;
                main_last_q <= in_last;
                main_data_q <= in_data;
                main_keep_q <= in_keep;
            end
        end else if (in_acc) begin
            skid_vld_q  <= 1'b1;
            skid_last_q <= in_last;
            skid_data_q <= in_data;
            skid_keep_q <= in_keep;
        end
    end

    assign s0_axis_cc_tready = s0_rdy;
    assign s1_axis_cc_tready = s1_rdy;
    assign m_axis_cc_tvalid  = main_vld_q;
    assign m_axis_cc_tlast   = main_vld_q & main_last_q;
    assign m_axis_cc_tdata   = main_vld_q ? main_data_q : '0;
    assign m_axis_cc_tkeep   = main_vld_q ? main_keep_q : '0;
    assign m_axis_cc_tuser   = '0;
    assign grant_state       = state_q;
    assign s0_pkt_cnt        = s0_cnt_q;
    assign s1_pkt_cnt        = s1_cnt_q;

endmodule

// File: tb/tb_cc_pkt_arbiter.sv
// Directed-vector bench for cc_pkt_arbiter: per-cycle table plus a
// counter-wrap sequence on a narrow-counter second instance.
module tb_cc_pkt_arbiter;

    localparam int DW  = 256;
    localparam int KW  = 8;
    localparam int CW  = 16;
    localparam int SCW = 3;

    localparam logic       Y  = 1'b1;
    localparam logic       N  = 1'b0;
    localparam logic [7:0] KA = 8'hFF;
    localparam logic [7:0] KB = 8'h0F;
    localparam logic [7:0] K0 = 8'h00;
    localparam logic [1:0] G0 = 2'd0;
    localparam logic [1:0] G1 = 2'd1;
    localparam logic [1:0] G2 = 2'd2;

    logic          pcie_clk = 1'b0;
    logic          pcie_rst_n;
    logic          s0_tvalid, s0_tlast, s1_tvalid, s1_tlast;
    logic [DW-1:0] s0_tdata, s1_tdata;
    logic [KW-1:0] s0_tkeep, s1_tkeep;
    logic          m_tready;

    logic          s0_tready, s1_tready, m_tvalid, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [32:0]   m_tuser;
    logic [1:0]    gs;
    logic [CW-1:0] c0, c1;

    logic           sm_s0_tready, sm_s1_tready, sm_tvalid, sm_tlast;
    logic [DW-1:0]  sm_tdata;
    logic [KW-1:0]  sm_tkeep;
    logic [32:0]    sm_tuser;
    logic [1:0]     sm_gs;
    logic [SCW-1:0] sm_c0, sm_c1;

    always #5 pcie_clk = ~pcie_clk;

    cc_pkt_arbiter #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
        .pcie_clk          (pcie_clk),
        .pcie_rst_n        (pcie_rst_n),
        .s0_axis_cc_tvalid (s0_tvalid),
        .s0_axis_cc_tlast  (s0_tlast),
        .s0_axis_cc_tdata  (s0_tdata),
        .s0_axis_cc_tkeep  (s0_tkeep),
        .s0_axis_cc_tready (s0_tready),
        .s1_axis_cc_tvalid (s1_tvalid),
        .s1_axis_cc_tlast  (s1_tlast),
        .s1_axis_cc_tdata  (s1_tdata),
        .s1_axis_cc_tkeep  (s1_tkeep),
        .s1_axis_cc_tready (s1_tready),
        .m_axis_cc_tvalid  (m_tvalid),
        .m_axis_cc_tlast   (m_tlast),
        .m_axis_cc_tdata   (m_tdata),
        .m_axis_cc_tkeep   (m_tkeep),
        .m_axis_cc_tuser   (m_tuser),
        .m_axis_cc_tready  (m_tready),
        .grant_state       (gs),
        .s0_pkt_cnt        (c0),
        .s1_pkt_cnt        (c1)
    );

    cc_pkt_arbiter #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(SCW)) dut_sm (
        .pcie_clk          (pcie_clk),
        .pcie_rst_n        (pcie_rst_n),
        .s0_axis_cc_tvalid (s0_tvalid),
        .s0_axis_cc_tlast  (s0_tlast),
        .s0_axis_cc_tdata  (s0_tdata),
        .s0_axis_cc_tkeep  (s0_tkeep),
        .s0_axis_cc_tready (sm_s0_tready),
        .s1_axis_cc_tvalid (s1_tvalid),
        .s1_axis_cc_tlast  (s1_tlast),
        .s1_axis_cc_tdata  (s1_tdata),
        .s1_axis_cc_tkeep  (s1_tkeep),
        .s1_axis_cc_tready (sm_s1_tready),
        .m_axis_cc_tvalid  (sm_tvalid),
        .m_axis_cc_tlast   (sm_tlast),
        .m_axis_cc_tdata   (sm_tdata),
        .m_axis_cc_tkeep   (sm_tkeep),
        .m_axis_cc_tuser   (sm_tuser),
        .m_axis_cc_tready  (m_tready),
        .grant_state       (sm_gs),
        .s0_pkt_cnt        (sm_c0),
        .s1_pkt_cnt        (sm_c1)
    );

    typedef struct {
        logic        rst;
        logic        s0v, s0l;
        logic [15:0] s0d;
        logic        s1v, s1l;
        logic [15:0] s1d;
        logic        mr;
        logic        ev, el;
        logic [15:0] ed;
        logic [7:0]  ek;
        logic        e0r, e1r;
        logic [1:0]  egs;
        logic [15:0] ec0, ec1;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic vec_t v(
        input logic rst, s0v, s0l, input logic [15:0] s0d,
        input logic s1v, s1l, input logic [15:0] s1d, input logic mr,
        input logic ev, el, input logic [15:0] ed, input logic [7:0] ek,
        input logic e0r, e1r, input logic [1:0] egs,
        input logic [15:0] ec0, ec1);
        vec_t r;
        r.rst = rst; r.s0v = s0v; r.s0l = s0l; r.s0d = s0d;
        r.s1v = s1v; r.s1l = s1l; r.s1d = s1d; r.mr = mr;
        r.ev = ev; r.el = el; r.ed = ed; r.ek = ek;
        r.e0r = e0r; r.e1r = e1r; r.egs = egs; r.ec0 = ec0; r.ec1 = ec1;
        return r;
    endfunction

    function automatic vec_t rst_row();
        return v(Y, N,N,16'h0, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0);
    endfunction

    task automatic check(input string name, input logic ok, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic drive(input vec_t r);
        pcie_rst_n = !r.rst;
        s0_tvalid  = r.s0v;
        s0_tlast   = r.s0l;
        s0_tdata   = {16{r.s0d}};
        s0_tkeep   = KA;
        s1_tvalid  = r.s1v;
        s1_tlast   = r.s1l;
        s1_tdata   = {16{r.s1d}};
        s1_tkeep   = KB;
        m_tready   = r.mr;
    endtask

    task automatic cmp_row(input int i, input vec_t r);
        logic [DW-1:0] xd;
        logic          ok;
        xd = r.ev ? {16{r.ed}} : '0;
        ok = (m_tvalid === r.ev) && (m_tlast === r.el) && (m_tdata === xd)
          && (m_tkeep === r.ek) && (m_tuser === 33'd0)
          && (s0_tready === r.e0r) && (s1_tready === r.e1r)
          && (gs === r.egs) && (c0 === r.ec0) && (c1 === r.ec1)
          && (sm_tvalid === r.ev) && (sm_tlast === r.el) && (sm_tdata === xd)
          && (sm_tkeep === r.ek) && (sm_tuser === 33'd0)
          && (sm_s0_tready === r.e0r) && (sm_s1_tready === r.e1r)
          && (sm_gs === r.egs) && (sm_c0 === r.ec0[SCW-1:0])
          && (sm_c1 === r.ec1[SCW-1:0]);
        check($sformatf("row%0d", i), ok,
              $sformatf("v/l/d/k/r0/r1/gs/c0/c1 got %b %b %h %h %b %b %h %h %h want %b %b %h %h %b %b %h %h %h",
                        m_tvalid, m_tlast, m_tdata[15:0], m_tkeep, s0_tready, s1_tready, gs, c0, c1,
                        r.ev, r.el, r.ed, r.ek, r.e0r, r.e1r, r.egs, r.ec0, r.ec1));
    endtask

    initial begin
        drive(rst_row());
        repeat (2) @(posedge pcie_clk);
        #1;

        // single s0 packet 1,2,3
        tbl.push_back(rst_row());
        tbl.push_back(v(N, Y,N,16'h1, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0));
        tbl.push_back(v(N, Y,N,16'h1, N,N,16'h0, Y, N,N,16'h0,K0, Y,N,G1, 16'd0,16'd0));
        tbl.push_back(v(N, Y,N,16'h2, N,N,16'h0, Y, Y,N,16'h1,KA, Y,N,G1, 16'd0,16'd0));
        tbl.push_back(v(N, Y,Y,16'h3, N,N,16'h0, Y, Y,N,16'h2,KA, Y,N,G1, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, Y,Y,16'h3,KA, N,N,G0, 16'd1,16'd0));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd1,16'd0));
        // simultaneous 2-beat packets
        tbl.push_back(rst_row());
        tbl.push_back(v(N, Y,N,16'h11, Y,N,16'h21, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0));
        tbl.push_back(v(N, Y,N,16'h11, Y,N,16'h21, Y, N,N,16'h0,K0, Y,N,G1, 16'd0,16'd0));
        tbl.push_back(v(N, Y,Y,16'h12, Y,N,16'h21, Y, Y,N,16'h11,KA, Y,N,G1, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h21, Y, Y,Y,16'h12,KA, N,N,G0, 16'd1,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h21, Y, N,N,16'h0,K0, N,Y,G2, 16'd1,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,Y,16'h22, Y, Y,N,16'h21,KB, N,Y,G2, 16'd1,16'd0));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, Y,Y,16'h22,KB, N,N,G0, 16'd1,16'd1));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd1,16'd1));
        // continuous single-beat requests, strict alternation
        tbl.push_back(rst_row());
        tbl.push_back(v(N, Y,Y,16'h30, Y,Y,16'h40, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0));
        tbl.push_back(v(N, Y,Y,16'h30, Y,Y,16'h40, Y, N,N,16'h0,K0, Y,N,G1, 16'd0,16'd0));
        tbl.push_back(v(N, Y,Y,16'h31, Y,Y,16'h40, Y, Y,Y,16'h30,KA, N,N,G0, 16'd1,16'd0));
        tbl.push_back(v(N, Y,Y,16'h31, Y,Y,16'h40, Y, N,N,16'h0,K0, N,Y,G2, 16'd1,16'd0));
        tbl.push_back(v(N, Y,Y,16'h31, Y,Y,16'h41, Y, Y,Y,16'h40,KB, N,N,G0, 16'd1,16'd1));
        tbl.push_back(v(N, Y,Y,16'h31, Y,Y,16'h41, Y, N,N,16'h0,K0, Y,N,G1, 16'd1,16'd1));
        tbl.push_back(v(N, Y,Y,16'h32, Y,Y,16'h41, Y, Y,Y,16'h31,KA, N,N,G0, 16'd2,16'd1));
        tbl.push_back(v(N, Y,Y,16'h32, Y,Y,16'h41, Y, N,N,16'h0,K0, N,Y,G2, 16'd2,16'd1));
        tbl.push_back(v(N, Y,Y,16'h32, Y,Y,16'h42, Y, Y,Y,16'h41,KB, N,N,G0, 16'd2,16'd2));
        tbl.push_back(v(N, Y,Y,16'h32, Y,Y,16'h42, Y, N,N,16'h0,K0, Y,N,G1, 16'd2,16'd2));
        tbl.push_back(v(N, Y,Y,16'h33, Y,Y,16'h42, Y, Y,Y,16'h32,KA, N,N,G0, 16'd3,16'd2));
        tbl.push_back(v(N, Y,Y,16'h33, Y,Y,16'h42, Y, N,N,16'h0,K0, N,Y,G2, 16'd3,16'd2));
        tbl.push_back(v(N, Y,Y,16'h33, Y,Y,16'h43, Y, Y,Y,16'h42,KB, N,N,G0, 16'd3,16'd3));
        tbl.push_back(v(N, Y,Y,16'h33, Y,Y,16'h43, Y, N,N,16'h0,K0, Y,N,G1, 16'd3,16'd3));
        tbl.push_back(v(N, N,N,16'h0, Y,Y,16'h43, Y, Y,Y,16'h33,KA, N,N,G0, 16'd4,16'd3));
        tbl.push_back(v(N, N,N,16'h0, Y,Y,16'h43, Y, N,N,16'h0,K0, N,Y,G2, 16'd4,16'd3));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, Y,Y,16'h43,KB, N,N,G0, 16'd4,16'd4));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd4,16'd4));
        // 5-cycle output stall inside a 4-beat s1 packet
        tbl.push_back(rst_row());
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h51, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h51, Y, N,N,16'h0,K0, N,Y,G2, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h52, N, Y,N,16'h51,KB, N,Y,G2, 16'd0,16'd0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(N, N,N,16'h0, Y,N,16'h53, N, Y,N,16'h51,KB, N,N,G2, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h53, Y, Y,N,16'h51,KB, N,N,G2, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h53, Y, Y,N,16'h52,KB, N,Y,G2, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,Y,16'h54, Y, Y,N,16'h53,KB, N,Y,G2, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, Y,Y,16'h54,KB, N,N,G0, 16'd0,16'd1));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd1));
        // reset during beat 2 of an s0 packet, then a clean s1 packet
        tbl.push_back(rst_row());
        tbl.push_back(v(N, Y,N,16'h61, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0));
        tbl.push_back(v(N, Y,N,16'h61, N,N,16'h0, Y, N,N,16'h0,K0, Y,N,G1, 16'd0,16'd0));
        tbl.push_back(v(Y, Y,N,16'h62, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h71, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,N,16'h71, Y, N,N,16'h0,K0, N,Y,G2, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, Y,Y,16'h72, Y, Y,N,16'h71,KB, N,Y,G2, 16'd0,16'd0));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, Y,Y,16'h72,KB, N,N,G0, 16'd0,16'd1));
        tbl.push_back(v(N, N,N,16'h0, N,N,16'h0, Y, N,N,16'h0,K0, N,N,G0, 16'd0,16'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge pcie_clk);
            cmp_row(i, tbl[i]);
            @(posedge pcie_clk);
            #1;
        end

        // counter wrap: 8 packets into the 3-bit instance reads 0
        drive(rst_row());
        @(posedge pcie_clk);
        #1;
        pcie_rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic        got;
            logic [15:0] xk;
            got       = 1'b0;
            xk        = 16'(k);
            s0_tvalid = 1'b1;
            s0_tlast  = 1'b1;
            s0_tdata  = {16{xk}};
            for (int t = 0; t < 6 && !got; t++) begin
                @(negedge pcie_clk);
                got = s0_tready;
                @(posedge pcie_clk);
                #1;
            end
            check($sformatf("wrap_hs%0d", k), got,
                  $sformatf("s0_tready seen %b want 1 within 6 cycles", got));
            check($sformatf("wrap_cnt%0d", k), (c0 === xk) && (sm_c0 === xk[SCW-1:0]),
                  $sformatf("cnt got %h/%h want %h/%h", c0, sm_c0, xk, xk[SCW-1:0]));
        end
        s0_tvalid = 1'b0;
        s0_tlast  = 1'b0;
        repeat (3) @(posedge pcie_clk);
        #1;
        check("wrap_final", (sm_c0 === 3'd0) && (c0 === 16'd8) && (c1 === 16'd0)
              && (m_tvalid === 1'b0) && (gs === G0),
              $sformatf("sm_c0=%h c0=%h c1=%h v=%b gs=%h want 0 8 0 0 0",
                        sm_c0, c0, c1, m_tvalid, gs));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
